// File: rtl/riscv_mc_controller.sv
// riscv_mc_controller: multi-cycle control FSM for the RV32I-subset core.
// Sequences fetch/decode/execute/writeback over a shared ALU and a unified
// req/ready memory, and keeps cycle/retired-instruction counters.
// Parameters:
//   CNT_W       - width of cycle_cnt / instret_cnt (wrapping)
//   MEM_TIMEOUT - max memory wait cycles before halting with mem_err (0 = never)
//   TMO_W       - width of the wait counter (MEM_TIMEOUT < 2**TMO_W)
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   - unknown opcodes halt with illegal=1 and are not retired
//   undefined - unknown opcodes retire as NOPs and illegal is tied low
module riscv_mc_controller #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 0,
    parameter int TMO_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             Zero,
    input  logic             lt,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic [2:0]       ImmSrc,
    output logic             done,
    output logic             mem_err,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXR    = 4'd2,
        S_EXI    = 4'd3,
        S_ALUWB  = 4'd4,
        S_MEMADR = 4'd5,
        S_MEMRD  = 4'd6,
        S_MEMWB  = 4'd7,
        S_MEMWR  = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_JALR   = 4'd11,
        S_JALR2  = 4'd12,
        S_LUI    = 4'd13,
        S_HALT   = 4'd14
    } state_t;

    localparam bit               TMO_EN    = (MEM_TIMEOUT > 0);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

    // ALU operation from funct3; funct7 selects sub only for register ops
    function automatic logic [2:0] alu_dec(input logic [2:0] f3,
                                           input logic [6:0] f7,
                                           input logic       use_f7);
        logic [2:0] res;
        res = 3'b000;
        case (f3)
            3'b000:  res = (use_f7 && (f7 == 7'b0100000)) ? 3'b001 : 3'b000;
            3'b111:  res = 3'b010;
            3'b110:  res = 3'b011;
            3'b010:  res = 3'b100;
            3'b100:  res = 3'b101;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    // Immediate format from the opcode, independent of FSM state
    function automatic logic [2:0] imm_dec(input logic [6:0] opc);
        logic [2:0] res;
        res = 3'b000;
        case (opc)
            7'b0100011: res = 3'b001;
            7'b1100011: res = 3'b010;
            7'b1101111: res = 3'b011;
            7'b0110111: res = 3'b100;
            default:    res = 3'b000;
        endcase
        return res;
    endfunction

    state_t             state_r;
    state_t             state_nx_s;
    logic [CNT_W-1:0]   cycle_cnt_r;
    logic [CNT_W-1:0]   instret_cnt_r;
    logic [TMO_W-1:0]   tmo_cnt_r;
    logic [TMO_W-1:0]   tmo_inc_s;
    logic               mem_err_r;
    logic               wait_state_s;
    logic               tmo_hit_s;
    logic               taken_s;
    logic               mem_req_s;
    logic               mem_write_s;
    logic               adr_src_s;
    logic               ir_write_s;
    logic               pc_write_s;
    logic               reg_write_s;
    logic [1:0]         result_src_s;
    logic [1:0]         alu_src_a_s;
    logic [1:0]         alu_src_b_s;
    logic [2:0]         alu_control_s;
`ifdef ILLEGAL_TRAP_EN
    logic               illegal_r;
    logic               illegal_set_s;
`endif

    assign wait_state_s = (state_r == S_FETCH) || (state_r == S_MEMRD) || (state_r == S_MEMWR);
    assign tmo_inc_s    = tmo_cnt_r + TMO_W'(1);
    // a ready in the final wait cycle is not a wait cycle, so ready wins
    assign tmo_hit_s    = TMO_EN && wait_state_s && !mem_ready && (tmo_inc_s == TMO_LIMIT);

    // Branch condition evaluation from funct3 and the ALU flags
    always_comb begin
        taken_s = 1'b0;
        case (funct3)
            3'b000:  taken_s = Zero;
            3'b001:  taken_s = !Zero;
            3'b100:  taken_s = lt;
            3'b101:  taken_s = !lt;
            default: taken_s = 1'b0;
        endcase
    end

    // Next-state and per-state strobes; every strobe defaults low
    always_comb begin
        state_nx_s    = state_r;
        mem_req_s     = 1'b0;
        mem_write_s   = 1'b0;
        adr_src_s     = 1'b0;
        ir_write_s    = 1'b0;
        pc_write_s    = 1'b0;
        reg_write_s   = 1'b0;
        result_src_s  = 2'b00;
        alu_src_a_s   = 2'b00;
        alu_src_b_s   = 2'b00;
        alu_control_s = 3'b000;
`ifdef ILLEGAL_TRAP_EN
        illegal_set_s = 1'b0;
`endif
        case (state_r)
            S_FETCH: begin
                mem_req_s = 1'b1;
                if (mem_ready) begin
                    ir_write_s   = 1'b1;
                    pc_write_s   = 1'b1;
                    alu_src_a_s  = 2'b00;
                    alu_src_b_s  = 2'b10;
                    result_src_s = 2'b10;
                    state_nx_s   = S_DECODE;
                end else if (tmo_hit_s) begin
                    state_nx_s = S_HALT;
                end else begin
                    state_nx_s = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
                case (op)
                    7'b0110011: state_nx_s = S_EXR;
                    7'b0010011: state_nx_s = S_EXI;
                    7'b0000011: state_nx_s = S_MEMADR;
                    7'b0100011: state_nx_s = S_MEMADR;
                    7'b1100011: state_nx_s = S_BRANCH;
                    7'b1101111: state_nx_s = S_JAL;
                    7'b1100111: state_nx_s = S_JALR;
                    7'b0110111: state_nx_s = S_LUI;
                    7'b0000000: state_nx_s = S_HALT;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_nx_s    = S_HALT;
                        illegal_set_s = 1'b1;
`else
                        state_nx_s    = S_FETCH;
`endif
                    end
                endcase
            end
            S_EXR: begin
                alu_src_a_s   = 2'b10;
                alu_src_b_s   = 2'b00;
                alu_control_s = alu_dec(funct3, funct7, 1'b1);
                state_nx_s    = S_ALUWB;
            end
            S_EXI: begin
                alu_src_a_s   = 2'b10;
                alu_src_b_s   = 2'b01;
                alu_control_s = alu_dec(funct3, funct7, 1'b0);
                state_nx_s    = S_ALUWB;
            end
            S_ALUWB: begin
                result_src_s = 2'b00;
                reg_write_s  = 1'b1;
                state_nx_s   = S_FETCH;
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                if (op == 7'b0000011) begin
                    state_nx_s = S_MEMRD;
                end else begin
                    state_nx_s = S_MEMWR;
                end
            end
            S_MEMRD: begin
                mem_req_s = 1'b1;
                adr_src_s = 1'b1;
                if (mem_ready) begin
                    state_nx_s = S_MEMWB;
                end else if (tmo_hit_s) begin
                    state_nx_s = S_HALT;
                end else begin
                    state_nx_s = S_MEMRD;
                end
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                state_nx_s   = S_FETCH;
            end
            S_MEMWR: begin
                mem_req_s   = 1'b1;
                mem_write_s = 1'b1;
                adr_src_s   = 1'b1;
                if (mem_ready) begin
                    state_nx_s = S_FETCH;
                end else if (tmo_hit_s) begin
                    state_nx_s = S_HALT;
                end else begin
                    state_nx_s = S_MEMWR;
                end
            end
            S_BRANCH: begin
                alu_src_a_s   = 2'b10;
                alu_src_b_s   = 2'b00;
                alu_control_s = 3'b001;
                result_src_s  = 2'b00;
                pc_write_s    = taken_s;
                state_nx_s    = S_FETCH;
            end
            S_JAL, S_JALR2: begin
                pc_write_s   = 1'b1;
                result_src_s = 2'b00;
                alu_src_a_s  = 2'b01;
                alu_src_b_s  = 2'b10;
                state_nx_s   = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                state_nx_s  = S_JALR2;
            end
            S_LUI: begin
                result_src_s = 2'b11;
                reg_write_s  = 1'b1;
                state_nx_s   = S_FETCH;
            end
            S_HALT: begin
                state_nx_s = S_HALT;
            end
            default: begin
                state_nx_s = S_FETCH;
            end
        endcase
    end

    // State, counters, wait timer and sticky halt flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_FETCH;
            cycle_cnt_r   <= '0;
            instret_cnt_r <= '0;
            tmo_cnt_r     <= '0;
            mem_err_r     <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_r     <= 1'b0;
`endif
        end else begin
            state_r <= state_nx_s;
            if (state_r != S_HALT) begin
                cycle_cnt_r <= cycle_cnt_r + CNT_W'(1);
            end
            if ((state_r != S_FETCH) && (state_nx_s == S_FETCH)) begin
                instret_cnt_r <= instret_cnt_r + CNT_W'(1);
            end
            if (TMO_EN && wait_state_s && !mem_ready) begin
                tmo_cnt_r <= tmo_inc_s;
            end else begin
                tmo_cnt_r <= '0;
            end
            mem_err_r <= mem_err_r | tmo_hit_s;
`ifdef ILLEGAL_TRAP_EN
            illegal_r <= illegal_r | illegal_set_s;
`endif
        end
    end

    // architectural writes are suppressed while reset is applied
    assign mem_req     = mem_req_s;
    assign MemWrite    = mem_write_s;
    assign AdrSrc      = adr_src_s;
    assign IRWrite     = ir_write_s  & ~rst;
    assign PCWrite     = pc_write_s  & ~rst;
    assign RegWrite    = reg_write_s & ~rst;
    assign ResultSrc   = result_src_s;
    assign ALUSrcA     = alu_src_a_s;
    assign ALUSrcB     = alu_src_b_s;
    assign ALUControl  = alu_control_s;
    assign ImmSrc      = imm_dec(op);
    assign done        = (state_r == S_HALT);
    assign mem_err     = mem_err_r;
    assign cycle_cnt   = cycle_cnt_r;
    assign instret_cnt = instret_cnt_r;
`ifdef ILLEGAL_TRAP_EN
    assign illegal     = illegal_r;
`else
    assign illegal     = 1'b0;
`endif

endmodule
